// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I opcode/funct constants, immediate types and the decode bundle
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_SW      = 3'b010;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_SH,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] store_data;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } bundle_t;

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - classifies the immediate format from the opcode and builds the sign-extended value
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o,
  output imm_type_e   imm_type_o
);

  logic [2:0] funct3;
  assign funct3 = instr_i[14:12];

  always_comb begin
    imm_type_o = IMM_NONE;
    case (instr_i[6:0])
      OPC_OP_IMM: imm_type_o = (funct3 == F3_SLL || funct3 == F3_SRL_SRA) ? IMM_SH : IMM_I;
      OPC_LOAD,
      OPC_JALR:   imm_type_o = IMM_I;
      OPC_STORE:  imm_type_o = IMM_S;
      OPC_BRANCH: imm_type_o = IMM_B;
      OPC_LUI,
      OPC_AUIPC:  imm_type_o = IMM_U;
      OPC_JAL:    imm_type_o = IMM_J;
      default:    imm_type_o = IMM_NONE;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (imm_type_o)
      IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_SH:  imm_o = {27'b0, instr_i[24:20]};
      IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm_o = imm_b(instr_i);
      IMM_U:   imm_o = {instr_i[31:12], 12'b0};
      IMM_J:   imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: single-entry valid/ready pipeline register feeding the ALU
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode_reg,
  output logic [2:0]      funct3_reg,
  output logic [6:0]      funct7_reg,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc_reg,
  output logic [4:0]      rd_reg,
  output logic            reg_write,
  output logic            illegal
);

  logic [31:0] imm;
  imm_type_e   imm_type;
  bundle_t     bundle_d, bundle_q;
  logic        valid_q;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic        writes;

  imm_gen u_imm_gen (
    .instr_i   (instr),
    .imm_o     (imm),
    .imm_type_o(imm_type)
  );

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  assign in_ready = !rst && (!valid_q || out_ready);

  always_comb begin
    bundle_d               = '0;
    writes                 = 1'b0;
    bundle_d.opcode        = opc;
    bundle_d.funct3        = f3;
    bundle_d.rd            = instr[11:7];
    bundle_d.pc            = pc;
    bundle_d.store_data    = rs2_data;
    bundle_d.branch_target = pc + imm_b(instr);
    bundle_d.src_a         = rs1_data;
    bundle_d.src_b         = imm;
    case (opc)
      OPC_OP: begin
        writes          = 1'b1;
        bundle_d.src_b  = rs2_data;
        bundle_d.funct7 = f7;
        if (f7 == F7_ALT)
          bundle_d.illegal = !(f3 == F3_ADD_SUB || f3 == F3_SRL_SRA);
        else
          bundle_d.illegal = (f7 != F7_BASE);
      end
      OPC_OP_IMM: begin
        writes = 1'b1;
        // Only shifts carry a meaningful funct7 (SRAI vs SRLI); other OP-IMM use those bits as imm.
        if (imm_type == IMM_SH) begin
          bundle_d.funct7 = f7;
          if (f3 == F3_SLL)
            bundle_d.illegal = (f7 != F7_BASE);
          else
            bundle_d.illegal = !(f7 == F7_BASE || f7 == F7_ALT);
        end
      end
      OPC_LOAD: begin
        writes           = 1'b1;
        bundle_d.illegal = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      end
      OPC_STORE: bundle_d.illegal = (f3 > F3_SW);
      OPC_BRANCH: begin
        // Branch compare is a subtract in the ALU.
        bundle_d.src_b   = rs2_data;
        bundle_d.funct7  = F7_ALT;
        bundle_d.illegal = (f3 == 3'b010 || f3 == 3'b011);
      end
      OPC_JALR: begin
        writes           = 1'b1;
        bundle_d.illegal = (f3 != 3'b000);
      end
      OPC_JAL: begin
        writes         = 1'b1;
        bundle_d.src_a = pc;
      end
      OPC_LUI: begin
        writes         = 1'b1;
        bundle_d.src_a = '0;
      end
      OPC_AUIPC: begin
        writes         = 1'b1;
        bundle_d.src_a = pc;
      end
      default: bundle_d.illegal = 1'b1;
    endcase
    bundle_d.reg_write = writes && (bundle_d.rd != 5'd0) && !bundle_d.illegal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q  <= 1'b1;
      bundle_q <= bundle_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign opcode_reg    = bundle_q.opcode;
  assign funct3_reg    = bundle_q.funct3;
  assign funct7_reg    = bundle_q.funct7;
  assign SrcA          = bundle_q.src_a;
  assign SrcB          = bundle_q.src_b;
  assign store_data    = bundle_q.store_data;
  assign branch_target = bundle_q.branch_target;
  assign pc_reg        = bundle_q.pc;
  assign rd_reg        = bundle_q.rd;
  assign reg_write     = bundle_q.reg_write;
  assign illegal       = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed-vector self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, reg_write, illegal;
  logic [31:0] instr, pc, rs1_data, rs2_data, SrcA, SrcB, store_data, branch_target, pc_reg;
  logic [4:0]  rs1_addr, rs2_addr, rd_reg;
  logic [6:0]  opcode_reg, funct7_reg;
  logic [2:0]  funct3_reg;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode_reg(opcode_reg), .funct3_reg(funct3_reg), .funct7_reg(funct7_reg),
    .SrcA(SrcA), .SrcB(SrcB), .store_data(store_data), .branch_target(branch_target),
    .pc_reg(pc_reg), .rd_reg(rd_reg), .reg_write(reg_write), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    instr = i; pc = p; rs1_data = a; rs2_data = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_srcb", SrcB, 0);
    rst = 1'b0;

    instr = 32'h002081B3; #1;
    check("add_rs1_addr", rs1_addr, 1);
    check("add_rs2_addr", rs2_addr, 2);
    send(32'h002081B3, 32'h0, 32'd5, 32'd7);
    check("add_valid", out_valid, 1);
    check("add_opcode", opcode_reg, 32'h33);
    check("add_f3", funct3_reg, 0);
    check("add_f7", funct7_reg, 0);
    check("add_srca", SrcA, 5);
    check("add_srcb", SrcB, 7);
    check("add_rd", rd_reg, 3);
    check("add_rw", reg_write, 1);
    check("add_illegal", illegal, 0);
    check("add_in_ready", in_ready, 1);

    send(32'hFFF00093, 32'h4, 32'd0, 32'd0);
    check("addi_srcb", SrcB, 32'hFFFFFFFF);
    check("addi_f7", funct7_reg, 0);
    check("addi_rw", reg_write, 1);

    send(32'h40335293, 32'h8, 32'd100, 32'd0);
    check("srai_f7", funct7_reg, 32'h20);
    check("srai_f3", funct3_reg, 5);
    check("srai_srcb", SrcB, 3);
    check("srai_illegal", illegal, 0);

    send(32'hFE208CE3, 32'h100, 32'd9, 32'h55);
    check("beq_target", branch_target, 32'hF8);
    check("beq_f7", funct7_reg, 32'h20);
    check("beq_srca", SrcA, 9);
    check("beq_srcb", SrcB, 32'h55);
    check("beq_rw", reg_write, 0);

    send(32'h0000007F, 32'h104, 32'd0, 32'd0);
    check("bad_valid", out_valid, 1);
    check("bad_illegal", illegal, 1);
    check("bad_rw", reg_write, 0);

    send(32'h123452B7, 32'h108, 32'd77, 32'd0);
    check("lui_srca", SrcA, 0);
    check("lui_srcb", SrcB, 32'h12345000);
    check("lui_rw", reg_write, 1);

    send(32'h00001317, 32'h200, 32'd77, 32'd0);
    check("auipc_srca", SrcA, 32'h200);
    check("auipc_srcb", SrcB, 32'h1000);

    send(32'h010000EF, 32'h300, 32'd77, 32'd0);
    check("jal_srca", SrcA, 32'h300);
    check("jal_srcb", SrcB, 16);
    check("jal_rd", rd_reg, 1);

    send(32'h0020A423, 32'h304, 32'h40, 32'hCAFE);
    check("sw_srcb", SrcB, 8);
    check("sw_store_data", store_data, 32'hCAFE);
    check("sw_rw", reg_write, 0);
    check("sw_illegal", illegal, 0);

    send(32'h40109093, 32'h308, 32'd1, 32'd0);
    check("slli_f7_illegal", illegal, 1);
    check("slli_f7_rw", reg_write, 0);

    send(32'h00208033, 32'h30C, 32'd1, 32'd2);
    check("add_x0_rw", reg_write, 0);
    check("add_x0_illegal", illegal, 0);

    send(32'h402091B3, 32'h310, 32'd1, 32'd2);
    check("alt_f3_illegal", illegal, 1);
    check("alt_f3_pc", pc_reg, 32'h310);

    // Backpressure: hold A for two cycles while B waits, then B appears exactly once.
    send(32'h002081B3, 32'h400, 32'd5, 32'd7);
    out_ready = 1'b0;
    instr = 32'hFFF00093; pc = 32'h404; rs1_data = 0; rs2_data = 0; in_valid = 1'b1;
    #1;
    check("bp_in_ready0", in_ready, 0);
    tick();
    check("bp_hold1_srcb", SrcB, 7);
    check("bp_hold1_valid", out_valid, 1);
    tick();
    check("bp_hold2_srcb", SrcB, 7);
    check("bp_hold2_opcode", opcode_reg, 32'h33);
    out_ready = 1'b1; #1;
    check("bp_in_ready1", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_b_valid", out_valid, 1);
    check("bp_b_srcb", SrcB, 32'hFFFFFFFF);
    check("bp_b_pc", pc_reg, 32'h404);
    tick();
    check("bp_b_once", out_valid, 0);

    // Flush with a held bundle and a new offer: neither emerges.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h500, 32'd5, 32'd7);
    check("fl_pre_valid", out_valid, 1);
    instr = 32'h123452B7; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid0", out_valid, 0);
    out_ready = 1'b1;
    tick();
    check("fl_still0", out_valid, 0);

    // Asynchronous reset mid-stream, then acceptance on the first edge after release.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h600, 32'd5, 32'd7);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_srcb", SrcB, 0);
    check("arst_rw", reg_write, 0);
    out_ready = 1'b1;
    instr = 32'h123452B7; pc = 32'h700; in_valid = 1'b1;
    tick();
    check("arst_hold", out_valid, 0);
    #2;
    rst = 1'b0;
    tick();
    in_valid = 1'b0;
    check("arst_first_valid", out_valid, 1);
    check("arst_first_srcb", SrcB, 32'h12345000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch offers instr/pc.
- in_ready  out  1  stage accepts this cycle.
- instr  in  32  RV32I instruction word.
- pc  in  32  address of instr.
- rs1_addr, rs2_addr  out  5 each  combinational from instr[19:15]/instr[24:20], to register file.
- rs1_data, rs2_data  in  32 each  same-cycle register-file read data.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  decoded bundle valid toward ALU.
- out_ready  in  1  ALU/execute consumes bundle.
- opcode_reg  out  7;  funct3_reg  out  3;  funct7_reg  out  7  (ALU control).
- SrcA, SrcB  out  32 each  ALU operands.
- store_data  out  32  rs2_data captured for stores.
- branch_target  out  32  pc + B-imm.
- pc_reg  out  32;  rd_reg  out  5;  reg_write  out  1;  illegal  out  1.

Function
REQ-003 Single-entry pipeline register; in_ready = !out_valid || out_ready.
REQ-004 Handshake: in_valid && in_ready captures the decoded bundle at the next edge; latency 1 cycle.
REQ-005 While out_valid && !out_ready, all outputs hold stable.
REQ-006 Simultaneous consume and accept: new bundle replaces old in one cycle, with no bubble.
REQ-007 Flush takes priority: next edge out_valid=0; any input accepted that cycle is dropped.
REQ-008 Immediates: I, S, B, U, J per RV32I, sign-extended to 32 bits; shift-immediate shamt = zero-extended instr[24:20].
REQ-009 SrcA selection:
- LUI: 0.
- AUIPC, JAL: pc.
- All others: rs1_data.
REQ-010 SrcB selection:
- R-type, branch: rs2_data.
- OP-IMM, load, JALR: I-imm (shamt for funct3 001/101).
- Store: S-imm.
- LUI, AUIPC: U-imm.
- JAL: J-imm.
REQ-011 funct7_reg:
- R-type: instr[31:25].
- OP-IMM: instr[31:25] for shifts only, else 0.
- Branch: 7'b0100000.
- All others: 0.
REQ-012 reg_write = 1 for R, OP-IMM, load, JALR, JAL, LUI, AUIPC when rd != 0; 0 otherwise.
REQ-013 illegal = 1 for any of:
- Unknown opcode.
- R-type funct7 not 0x00/0x20, or 0x20 with funct3 not 000/101.
- Bad shift funct7.
- Branch funct3 010/011.
- Load funct3 011/110/111.
- Store funct3 > 010.
- JALR funct3 != 0.
REQ-014 Illegal bundle still asserts out_valid, with reg_write=0.
REQ-015 No instruction is duplicated or lost across any backpressure pattern.

Reset
REQ-016 rst asynchronously clears out_valid and every registered output to 0; in_ready=0 while rst is high.
REQ-017 Reset mid-transfer discards the held bundle; first acceptance occurs on the first edge after rst deasserts.

Structure
REQ-018 Shared package rv_pkg holds opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1101111, 0110111, 0010111), funct3/funct7 constants and the immediate-type enum.
REQ-019 One sub-module imm_gen (instr -> 32-bit immediate plus type); everything else is inline.

Verification
REQ-020 Scenario: instr=0x002081B3 (add x3,x1,x2), rs1_data=5, rs2_data=7 -> next cycle out_valid=1, opcode_reg=0x33, funct3_reg=0, funct7_reg=0, SrcA=5, SrcB=7, rd_reg=3, reg_write=1.
REQ-021 Scenario: instr=0xFFF00093 (addi x1,x0,-1) -> SrcB=0xFFFFFFFF, funct7_reg=0; instr=0x40335293 (srai x5,x6,3) -> funct7_reg=0x20, funct3_reg=5, SrcB=3.
REQ-022 Scenario: beq x1,x2,-8 at pc=0x100 -> branch_target=0x000000F8, funct7_reg=0x20, SrcB=rs2_data, reg_write=0.
REQ-023 Scenario: out_ready=0 for 2 cycles while a second instr is offered -> in_ready=0 and outputs frozen; then out_ready=1 -> second bundle appears exactly once, the next cycle.
REQ-024 Scenario: flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, neither instruction emitted; rst pulse mid-stream -> out_valid=0 immediately, without waiting for a clock edge.
REQ-025 Scenario: instr=0x0000007F -> out_valid=1, illegal=1, reg_write=0.
